// File: rtl/inst_fetch_bridge.sv
// Instruction fetch bridge: turns core PC requests into single SRAM-like bus
// transactions, drops redirect-stale responses, flags misaligned PCs, counts stalls.
module inst_fetch_bridge #(
  parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic [31:0] inst,
  output logic        inst_ready,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic        adef,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        stale_q, stale_d;
  logic [31:0] inst_q, inst_d;
  logic        adef_q, adef_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic        in_flight;
  logic        stale_now;
  logic        stale_eff;

  // The current cycle's redirect counts too, so data arriving on the same
  // cycle the PC moves away is already treated as stale.
  assign in_flight = (state_q == REQ) || (state_q == WAIT);
  assign stale_now = in_flight && (!pc_valid || (pc != req_pc_q));
  assign stale_eff = stale_q || stale_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      req_pc_q       <= 32'h0;
      stale_q        <= 1'b0;
      inst_q         <= NOP_INST;
      adef_q         <= 1'b0;
      stall_cycles_q <= 32'h0;
    end else begin
      state_q        <= state_d;
      req_pc_q       <= req_pc_d;
      stale_q        <= stale_d;
      inst_q         <= inst_d;
      adef_q         <= adef_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    stale_d  = stale_q;
    inst_d   = inst_q;
    adef_d   = adef_q;
    if (in_flight) begin
      stale_d = stale_eff;
    end
    unique case (state_q)
      IDLE: begin
        if (pc_valid) begin
          if (pc[1:0] == 2'b00) begin
            req_pc_d = pc;
            stale_d  = 1'b0;
            state_d  = REQ;
          end else begin
            inst_d  = NOP_INST;
            adef_d  = 1'b1;
            state_d = RESP;
          end
        end
      end
      REQ: begin
        // Data without a prior address handshake is a bus violation and is ignored.
        if (inst_addr_ok) begin
          if (inst_data_ok) begin
            if (stale_eff) begin
              state_d = IDLE;
            end else begin
              inst_d  = inst_rdata;
              state_d = RESP;
            end
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (inst_data_ok) begin
          if (stale_eff) begin
            state_d = IDLE;
          end else begin
            inst_d  = inst_rdata;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        adef_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (pc_valid && (state_q != RESP) && (stall_cycles_q != STALL_MAX)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  assign inst_req     = (state_q == REQ);
  assign inst_addr    = req_pc_q;
  assign inst_ready   = (state_q == RESP);
  assign adef         = (state_q == RESP) && adef_q;
  assign inst         = inst_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed self-checking bench for inst_fetch_bridge: fetch latency, stale
// discard, address hold, misaligned PC, async reset and stall saturation.
module tb_inst_fetch_bridge;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic        adef;
  logic [31:0] stall_cycles;

  int testsRun;
  int failCount;

  localparam logic [31:0] NOP = 32'h0340_0000;

  inst_fetch_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .inst         (inst),
    .inst_ready   (inst_ready),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok),
    .adef         (adef),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge, inputs driven there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] p, input logic aok,
                               input logic dok, input logic [31:0] rd);
    pc_valid     = v;
    pc           = p;
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rd;
  endtask

  initial begin
    testsRun  = 0;
    failCount = 0;
    reset     = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    checkOutput("reset_inst", inst, NOP);
    checkOutput("reset_ready", {31'b0, inst_ready}, 32'd0);
    checkOutput("reset_req", {31'b0, inst_req}, 32'd0);
    checkOutput("reset_addr", inst_addr, 32'h0);
    checkOutput("reset_adef", {31'b0, adef}, 32'd0);
    checkOutput("reset_stall", stall_cycles, 32'h0);
    reset = 1'b0;

    // Basic fetch: addr_ok in cycle 1, data_ok in cycle 2, ready in cycle 3.
    applyStimulus(1'b1, 32'h1C00_0000, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("basic_req_c1", {31'b0, inst_req}, 32'd1);
    checkOutput("basic_addr_c1", inst_addr, 32'h1C00_0000);
    applyStimulus(1'b1, 32'h1C00_0000, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("basic_noready_c2", {31'b0, inst_ready}, 32'd0);
    applyStimulus(1'b1, 32'h1C00_0000, 1'b0, 1'b1, 32'h0280_0C0C);
    tick();
    checkOutput("basic_ready_c3", {31'b0, inst_ready}, 32'd1);
    checkOutput("basic_inst", inst, 32'h0280_0C0C);
    checkOutput("basic_stall", stall_cycles, 32'd3);
    applyStimulus(1'b0, 32'h1C00_0000, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("basic_ready_pulse", {31'b0, inst_ready}, 32'd0);

    // Zero-wait bus: both handshakes in the REQ cycle.
    applyStimulus(1'b1, 32'h1C00_0008, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("zw_req_c1", {31'b0, inst_req}, 32'd1);
    applyStimulus(1'b1, 32'h1C00_0008, 1'b1, 1'b1, 32'h1500_0001);
    tick();
    applyStimulus(1'b0, 32'h1C00_0008, 1'b0, 1'b0, 32'h0);
    checkOutput("zw_req_c2", {31'b0, inst_req}, 32'd0);
    checkOutput("zw_ready_c2", {31'b0, inst_ready}, 32'd1);
    checkOutput("zw_inst", inst, 32'h1500_0001);
    tick();

    // Redirect during WAIT: old data must be discarded.
    applyStimulus(1'b1, 32'h1C00_0004, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("redir_addr_old", inst_addr, 32'h1C00_0004);
    applyStimulus(1'b1, 32'h1C00_0004, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h1C00_0100, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h1C00_0100, 1'b0, 1'b1, 32'hDEAD_BEEF);
    tick();
    applyStimulus(1'b1, 32'h1C00_0100, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_no_ready", {31'b0, inst_ready}, 32'd0);
    checkOutput("redir_inst_held", inst, 32'h1500_0001);
    tick();
    checkOutput("redir_new_req", {31'b0, inst_req}, 32'd1);
    checkOutput("redir_new_addr", inst_addr, 32'h1C00_0100);
    applyStimulus(1'b1, 32'h1C00_0100, 1'b1, 1'b1, 32'h1234_5678);
    tick();
    applyStimulus(1'b0, 32'h1C00_0100, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_ready", {31'b0, inst_ready}, 32'd1);
    checkOutput("redir_inst", inst, 32'h1234_5678);
    tick();

    // Address hold while addr_ok is withheld and the PC wanders.
    applyStimulus(1'b1, 32'h1C00_0200, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold_req_%0d", i), {31'b0, inst_req}, 32'd1);
      checkOutput($sformatf("hold_addr_%0d", i), inst_addr, 32'h1C00_0200);
      applyStimulus(1'b1, 32'h1C00_0204 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
      tick();
    end
    applyStimulus(1'b1, 32'h1C00_0214, 1'b1, 1'b1, 32'hAAAA_5555);
    tick();
    applyStimulus(1'b0, 32'h1C00_0214, 1'b0, 1'b0, 32'h0);
    checkOutput("hold_discard_ready", {31'b0, inst_ready}, 32'd0);
    checkOutput("hold_discard_inst", inst, 32'h1234_5678);
    tick();
    checkOutput("hold_idle_req", {31'b0, inst_req}, 32'd0);

    // Misaligned PC: one-cycle adef response with no bus request.
    applyStimulus(1'b1, 32'h1C00_0002, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("mis_no_req_c0", {31'b0, inst_req}, 32'd0);
    tick();
    applyStimulus(1'b0, 32'h1C00_0002, 1'b0, 1'b0, 32'h0);
    checkOutput("mis_no_req_c1", {31'b0, inst_req}, 32'd0);
    checkOutput("mis_ready", {31'b0, inst_ready}, 32'd1);
    checkOutput("mis_adef", {31'b0, adef}, 32'd1);
    checkOutput("mis_inst", inst, NOP);
    tick();
    checkOutput("mis_adef_clear", {31'b0, adef}, 32'd0);

    // Asynchronous reset while in WAIT, then a late data_ok.
    applyStimulus(1'b1, 32'h1C00_0300, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h1C00_0300, 1'b1, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h1C00_0300, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    checkOutput("arst_req", {31'b0, inst_req}, 32'd0);
    checkOutput("arst_addr", inst_addr, 32'h0);
    checkOutput("arst_inst", inst, NOP);
    checkOutput("arst_stall", stall_cycles, 32'h0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 32'h1C00_0300, 1'b0, 1'b1, 32'hCAFE_F00D);
    tick();
    checkOutput("arst_late_ready0", {31'b0, inst_ready}, 32'd0);
    applyStimulus(1'b0, 32'h1C00_0300, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("arst_late_ready1", {31'b0, inst_ready}, 32'd0);
    checkOutput("arst_late_inst", inst, NOP);

    // Stall counter saturation, preloaded just below the ceiling.
    applyStimulus(1'b1, 32'h1C00_0400, 1'b0, 1'b0, 32'h0);
    tick();
    dut.stall_cycles_q = 32'hFFFF_FFFD;
    tick();
    checkOutput("sat_fffe", stall_cycles, 32'hFFFF_FFFE);
    tick();
    checkOutput("sat_ffff", stall_cycles, 32'hFFFF_FFFF);
    tick();
    checkOutput("sat_hold0", stall_cycles, 32'hFFFF_FFFF);
    tick();
    checkOutput("sat_hold1", stall_cycles, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/inst_fetch_bridge.md
# inst_fetch_bridge

Instruction-side bridge between the core's fetch port (`PC`, `pc_valid`, `inst`, `inst_ready`) and a variable-latency SRAM-like instruction bus (`req`/`addr_ok`/`data_ok`). It sits directly downstream of the core top and converts each PC request into one bus transaction. It returns the fetched word with a one-cycle `inst_ready` pulse. It also drops responses made stale by a PC redirect, flags misaligned PCs, and counts fetch stall cycles.

## Interface
- `NOP_INST`, default 32'h0340_0000: word returned on reset and for misaligned PCs.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous reset, active-high.
- `pc`  in  32  fetch address from the core (`PC`).
- `pc_valid`  in  1  core requests fetch of `pc`.
- `inst`  out  32  fetched instruction; held between updates.
- `inst_ready`  out  1  one-cycle pulse: `inst` is valid for the current `pc`.
- `inst_req`  out  1  bus request.
- `inst_addr`  out  32  bus address; stable while `inst_req`=1.
- `inst_addr_ok`  in  1  bus accepted the address this cycle.
- `inst_rdata`  in  32  bus read data.
- `inst_data_ok`  in  1  `inst_rdata` is valid this cycle.
- `adef`  out  1  one-cycle pulse with `inst_ready` when the PC was misaligned.
- `stall_cycles`  out  32  saturating stall counter.

## Operation
- The bridge has four states: IDLE, REQ, WAIT and RESP. At most one bus transaction is outstanding at any time.
- **IDLE**
  - If `pc_valid`=1 and `pc[1:0]`=0: latch `req_pc`<=`pc`, clear `stale`, go to REQ.
  - If `pc_valid`=1 and `pc[1:0]`!=0: set `inst`<=`NOP_INST` and `adef_q`<=1, go to RESP. No bus request is issued.
  - `inst_data_ok` is ignored in IDLE.
- **REQ**
  - `inst_req`=1 and `inst_addr`=`req_pc`, both driven combinationally from state. The address must not change until `inst_addr_ok`.
  - On `inst_addr_ok`=1: go to WAIT.
  - If `inst_data_ok`=1 in the same cycle, the cycle is treated as WAIT completion (below).
- **WAIT**
  - On `inst_data_ok`=1 with `stale`=0: set `inst`<=`inst_rdata` and go to RESP.
  - On `inst_data_ok`=1 with `stale`=1: discard the data and go to IDLE.
- **RESP**
  - `inst_ready`=1 and `adef`=`adef_q`.
  - Next state is IDLE; `adef_q` clears.
- **Stale detection**
  - `stale` is set in any REQ or WAIT cycle where `pc_valid`=0 or `pc`!=`req_pc`.
  - It is sticky until the next IDLE->REQ transition.
- **`inst` register:** updated only on a non-stale response or a misaligned PC; otherwise it holds its value.
- **`stall_cycles`:** increments each cycle where `pc_valid`=1 and `inst_ready`=0. It saturates at 32'hFFFF_FFFF and does not wrap.

## Timing
- **Reset values (asynchronous):**
  - state=IDLE
  - `inst`=`NOP_INST`
  - `inst_ready`=0, `inst_req`=0, `inst_addr`=0, `adef`=0
  - `stall_cycles`=0, `stale`=0, `req_pc`=0
- **Latency**
  - Minimum pc_valid->inst_ready is 2 cycles, when `inst_addr_ok` and `inst_data_ok` both arrive in the REQ cycle.
  - With `addr_ok` in cycle 1 and `data_ok` in cycle 2, it is 3 cycles.
  - Misaligned PC: 1 cycle.
- **Back-to-back:** after RESP, a new request enters REQ no earlier than 2 cycles later (RESP->IDLE->REQ).
- **Stale response:** costs an extra round trip; the fresh `pc` is sampled in the IDLE cycle after the discard.
- **Reset mid-transaction:** the bridge returns to IDLE immediately. Late `inst_data_ok` arriving after reset is ignored.
- **Protocol-violation behaviour:** `inst_data_ok` before `inst_addr_ok` (other than in the same cycle) is a bus violation and is ignored in REQ.
- **Outputs:** `inst_req` and `inst_ready` are purely state-decoded, so there is no combinational path from bus inputs.

## Test plan
- **Basic fetch:** reset, then `pc`=0x1C000000 and `pc_valid`=1, `addr_ok` in cycle 1, `data_ok` in cycle 2 with `rdata`=0x02800C0C. Required: `inst_addr`=0x1C000000 in cycle 1, `inst_ready` pulse in cycle 3, `inst`=0x02800C0C, `stall_cycles`=3.
- **Zero-wait bus:** `addr_ok` and `data_ok` both in the REQ cycle, `rdata`=0x15000001. Required: `inst_ready` in cycle 2; `inst_req` high for exactly 1 cycle.
- **Redirect during WAIT:**
  - Stimulus: `pc` changes from 0x1C000004 to 0x1C000100 after `addr_ok`; old `data_ok` returns 0xDEADBEEF.
  - Required: no `inst_ready` for 0xDEADBEEF; `inst` unchanged; a new REQ with `inst_addr`=0x1C000100; `inst_ready` only with its data.
- **Address hold:** `addr_ok` withheld for 5 cycles while `pc` changes. Required: `inst_addr` constant at the original `req_pc` for all 5 cycles, and the response is discarded.
- **Misaligned PC:** `pc`=0x1C000002 with `pc_valid`=1. Required: no `inst_req`; next cycle `inst_ready`=1, `adef`=1, `inst`=0x03400000.
- **Reset and saturation:**
  - Assert `reset` while in WAIT: all outputs return to reset values asynchronously, and a following `data_ok` produces no `inst_ready`.
  - Force `stall_cycles` near 32'hFFFF_FFFE with `pc_valid` held and no response: the counter holds at 32'hFFFF_FFFF.
